// File: rtl/dll_rx_tlp_seq_if.sv
// rtl/dll_rx_tlp_seq_if.sv - DLL RX TLP path bus: demux input, TL output, ACK/NAK request channel
interface dll_rx_tlp_seq_if #(
    parameter int DATA_W = 128,
    parameter int SEQ_W  = 12
);
    logic [1:0]        dlc_state_i;
    logic [DATA_W-1:0] pkt_i;
    logic [SEQ_W-1:0]  seq_i;
    logic              lcrc_err_i;
    logic              pkt_valid_i;
    logic              is_tlp_i;
    logic [DATA_W-1:0] tlp_o;
    logic              tlp_valid_o;
    logic              tlp_ready_i;
    logic              ack_req_o;
    logic              ack_nak_o;
    logic [SEQ_W-1:0]  ack_seq_o;
    logic              ack_ready_i;

    modport master (
        output dlc_state_i, pkt_i, seq_i, lcrc_err_i, pkt_valid_i, is_tlp_i,
        output tlp_ready_i, ack_ready_i,
        input  tlp_o, tlp_valid_o, ack_req_o, ack_nak_o, ack_seq_o
    );

    modport slave (
        input  dlc_state_i, pkt_i, seq_i, lcrc_err_i, pkt_valid_i, is_tlp_i,
        input  tlp_ready_i, ack_ready_i,
        output tlp_o, tlp_valid_o, ack_req_o, ack_nak_o, ack_seq_o
    );
endinterface

// File: rtl/dll_rx_tlp_seq.sv
// rtl/dll_rx_tlp_seq.sv - DLL RX sequence check, TLP FIFO and ACK/NAK requests; option DLL_RX_ACK_COALESCE_EN
module dll_rx_tlp_seq #(
    parameter int DATA_W       = 128,
    parameter int SEQ_W        = 12,
    parameter int FIFO_DEPTH   = 4,
    parameter int ACK_COALESCE = 4,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    dll_rx_tlp_seq_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_count;
    logic [SEQ_W-1:0]  r_next_seq;
    logic              r_nak_sched;
    logic              r_pend_ack;
    logic              r_pend_nak;
    logic              r_ack_req;
    logic              r_ack_nak;
    logic [SEQ_W-1:0]  r_ack_seq;

    logic              w_clr;
    logic              w_cand;
    logic              w_full;
    logic              w_pop;
    logic              w_seq_hit;
    logic [SEQ_W-1:0]  w_dist;
    logic              w_push;
    logic              w_dup;
    logic              w_bad;
    logic              w_nak_ev;
    logic              w_ack_ev;
    logic              w_pend_ack;
    logic              w_pend_nak;
    logic              w_issue;
    logic [SEQ_W-1:0]  w_next_seq_nxt;

    // Leaving DL_Active behaves exactly like a reset one cycle later.
    assign w_clr     = rst | (bus.dlc_state_i != 2'b11);
    assign w_cand    = bus.pkt_valid_i & bus.is_tlp_i & (bus.dlc_state_i == 2'b11);
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop     = (r_count != '0) & bus.tlp_ready_i;
    assign w_seq_hit = (bus.seq_i == r_next_seq);
    assign w_dist    = r_next_seq - SEQ_W'(1) - bus.seq_i;

    assign w_push = w_cand & ~bus.lcrc_err_i & w_seq_hit & (~w_full | w_pop);
    assign w_dup  = w_cand & ~bus.lcrc_err_i & ~w_seq_hit & ~w_dist[SEQ_W-1];
    assign w_bad  = w_cand & ~w_push & ~w_dup;

    assign w_nak_ev       = w_bad & ~r_nak_sched;
    assign w_next_seq_nxt = r_next_seq + SEQ_W'(w_push);

`ifdef DLL_RX_ACK_COALESCE_EN
    localparam int CNT_W = $clog2(ACK_COALESCE + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W:0]   w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_push);
    assign w_ack_ev  = w_dup
                     | (w_cnt_sum >= (CNT_W+1)'(ACK_COALESCE))
                     | (r_timer >= TMR_W'(ACK_TIMEOUT));

    // Any issued request acknowledges everything received so far.
    always_ff @(posedge clk) begin
        if (w_clr || w_issue) begin
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            r_cnt <= (w_cnt_sum >= (CNT_W+1)'(ACK_COALESCE)) ? CNT_W'(ACK_COALESCE)
                                                              : w_cnt_sum[CNT_W-1:0];
            if ((r_cnt != '0) && (r_timer < TMR_W'(ACK_TIMEOUT)))
                r_timer <= r_timer + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = ACK_COALESCE ^ ACK_TIMEOUT;
    assign w_ack_ev     = w_push | w_dup;
`endif

    // Merge this cycle's events into whatever is still waiting; NAK wins.
    assign w_pend_ack = r_pend_ack | w_ack_ev;
    assign w_pend_nak = r_pend_nak | w_nak_ev;
    assign w_issue    = (~r_ack_req | bus.ack_ready_i) & (w_pend_ack | w_pend_nak);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_next_seq  <= '0;
            r_nak_sched <= 1'b0;
            r_pend_ack  <= 1'b0;
            r_pend_nak  <= 1'b0;
            r_ack_req   <= 1'b0;
            r_ack_nak   <= 1'b0;
            r_ack_seq   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
            r_next_seq <= w_next_seq_nxt;

            if (w_push)
                r_nak_sched <= 1'b0;
            else if (w_bad)
                r_nak_sched <= 1'b1;

            if (w_issue) begin
                r_ack_req  <= 1'b1;
                r_ack_nak  <= w_pend_nak;
                r_ack_seq  <= w_next_seq_nxt - SEQ_W'(1);
                r_pend_ack <= 1'b0;
                r_pend_nak <= 1'b0;
            end else begin
                if (bus.ack_ready_i)
                    r_ack_req <= 1'b0;
                r_pend_ack <= w_pend_ack;
                r_pend_nak <= w_pend_nak;
            end
        end
    end

    // A push into a full FIFO lands in the slot being popped in the same cycle.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.pkt_i;
    end

    assign bus.tlp_valid_o = (r_count != '0);
    assign bus.tlp_o       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.ack_req_o   = r_ack_req;
    assign bus.ack_nak_o   = r_ack_nak;
    assign bus.ack_seq_o   = r_ack_seq;
endmodule

// File: tb/tb_dll_rx_tlp_seq.sv
// tb/tb_dll_rx_tlp_seq.sv - self-checking bench for dll_rx_tlp_seq (directed scenarios + random vs queue model)
module tb_dll_rx_tlp_seq;
    localparam int DATA_W = 128;
    localparam int SEQ_W  = 12;
    localparam int DEPTH  = 4;
    localparam int MOD    = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dll_rx_tlp_seq_if #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) bus ();

    dll_rx_tlp_seq #(
        .DATA_W(DATA_W), .SEQ_W(SEQ_W), .FIFO_DEPTH(DEPTH),
        .ACK_COALESCE(4), .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] m_fifo[$];
    int m_next;
    bit m_nak_sched, m_pend_ack, m_pend_nak, m_req, m_nak;
    int m_seq;
    logic [DATA_W-1:0] saved;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit full, pop, ack_ev, nak_ev, bad;
        int s;
        if (rst || bus.dlc_state_i != 2'b11) begin
            m_fifo.delete();
            m_next = 0; m_nak_sched = 0; m_pend_ack = 0; m_pend_nak = 0;
            m_req = 0; m_nak = 0; m_seq = 0;
            return;
        end
        full = (m_fifo.size() == DEPTH);
        pop  = (m_fifo.size() > 0) && bus.tlp_ready_i;
        if (pop) void'(m_fifo.pop_front());
        ack_ev = 0;
        bad = 0;
        if (bus.pkt_valid_i && bus.is_tlp_i) begin
            s = int'(bus.seq_i);
            if (bus.lcrc_err_i) bad = 1;
            else if (s == m_next) begin
                if (!full || pop) begin
                    m_fifo.push_back(bus.pkt_i);
                    m_next = (m_next + 1) % MOD;
                    m_nak_sched = 0;
                    ack_ev = 1;
                end else bad = 1;
            end
            else if ((((m_next - 1 - s) % MOD) + MOD) % MOD < MOD / 2) ack_ev = 1;
            else bad = 1;
        end
        nak_ev = bad && !m_nak_sched;
        if (bad) m_nak_sched = 1;
        m_pend_ack |= ack_ev;
        m_pend_nak |= nak_ev;
        if (!m_req || bus.ack_ready_i) begin
            if (m_pend_ack || m_pend_nak) begin
                m_req = 1;
                m_nak = m_pend_nak;
                m_seq = (m_next + MOD - 1) % MOD;
                m_pend_ack = 0;
                m_pend_nak = 0;
            end else m_req = 0;
        end
    endtask

    task automatic check_outputs();
        chk("tlp_valid", bus.tlp_valid_o, m_fifo.size() != 0);
        chk("tlp_data", bus.tlp_o, (m_fifo.size() != 0) ? m_fifo[0] : '0);
        chk("ack_req", bus.ack_req_o, m_req);
        if (m_req) begin
            chk("ack_nak", bus.ack_nak_o, m_nak);
            chk("ack_seq", bus.ack_seq_o, m_seq);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input int seq, input bit lcrc);
        bus.pkt_valid_i = 1'b1;
        bus.is_tlp_i    = 1'b1;
        bus.seq_i       = SEQ_W'(seq);
        bus.lcrc_err_i  = lcrc;
        bus.pkt_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        bus.pkt_valid_i = 1'b0;
        bus.lcrc_err_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pkt_valid_i = 1'b0;
        bus.lcrc_err_i  = 1'b0;
        tick();
        chk("rst_tlp_valid", bus.tlp_valid_o, 0);
        chk("rst_tlp_data", bus.tlp_o, 0);
        chk("rst_ack_req", bus.ack_req_o, 0);
        chk("rst_ack_nak", bus.ack_nak_o, 0);
        chk("rst_ack_seq", bus.ack_seq_o, 0);
        rst = 1'b0;
        bus.dlc_state_i = 2'b11;
    endtask

    initial begin
        rst = 1'b1;
        bus.dlc_state_i = 2'b00;
        bus.pkt_i = '0;
        bus.seq_i = '0;
        bus.lcrc_err_i = 1'b0;
        bus.pkt_valid_i = 1'b0;
        bus.is_tlp_i = 1'b0;
        bus.tlp_ready_i = 1'b1;
        bus.ack_ready_i = 1'b1;
        @(negedge clk);
        do_reset();

        // In-order stream drains straight to the TL
        for (int i = 0; i < 3; i++) begin
            send(i, 1'b0);
            chk("t1_valid", bus.tlp_valid_o, 1);
        end
        chk("t1_ack_seq", bus.ack_seq_o, 2);
        chk("t1_ack_nak", bus.ack_nak_o, 0);

        // Gap gives a single NAK until the missing TLP arrives
        do_reset();
        send(0, 1'b0);
        send(2, 1'b0);
        chk("t2_nak", bus.ack_nak_o, 1);
        chk("t2_nak_seq", bus.ack_seq_o, 0);
        send(3, 1'b0);
        chk("t2_no_second_nak", bus.ack_req_o, 0);
        send(1, 1'b0);
        chk("t2_ack_seq1", bus.ack_seq_o, 1);
        chk("t2_ack_nak0", bus.ack_nak_o, 0);
        send(3, 1'b0);
        chk("t2_nak_again", bus.ack_nak_o, 1);

        // Duplicate gets an immediate ACK and leaves the FIFO alone
        do_reset();
        for (int i = 0; i < 5; i++) send(i, 1'b0);
        bus.tlp_ready_i = 1'b0;
        saved = bus.tlp_o;
        send(3, 1'b0);
        chk("t3_dup_req", bus.ack_req_o, 1);
        chk("t3_dup_nak", bus.ack_nak_o, 0);
        chk("t3_dup_seq", bus.ack_seq_o, 4);
        chk("t3_fifo_head", bus.tlp_o, saved);

        // Overflow: the DEPTH+1-th TLP is NAKed, head held
        do_reset();
        bus.tlp_ready_i = 1'b0;
        send(0, 1'b0);
        saved = m_fifo[0];
        for (int i = 1; i <= DEPTH; i++) send(i, 1'b0);
        chk("t4_nak", bus.ack_nak_o, 1);
        chk("t4_nak_seq", bus.ack_seq_o, DEPTH - 1);
        chk("t4_head_stable", bus.tlp_o, saved);
        chk("t4_valid", bus.tlp_valid_o, 1);
        bus.tlp_ready_i = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();

        // Sequence wrap
        do_reset();
        for (int i = 0; i < MOD - 2; i++) send(i, 1'b0);
        send(4094, 1'b0);
        send(4095, 1'b0);
        send(0, 1'b0);
        chk("t5_wrap_seq", bus.ack_seq_o, 0);
        chk("t5_wrap_nak", bus.ack_nak_o, 0);

        // Stalled request channel, NAK merged behind a frozen ACK
        do_reset();
        bus.ack_ready_i = 1'b0;
        send(0, 1'b0);
        send(5, 1'b1);
        tick();
        chk("t6_frozen_req", bus.ack_req_o, 1);
        chk("t6_frozen_nak", bus.ack_nak_o, 0);
        chk("t6_frozen_seq", bus.ack_seq_o, 0);
        bus.ack_ready_i = 1'b1;
        tick();
        chk("t6_nak_req", bus.ack_req_o, 1);
        chk("t6_nak_after", bus.ack_nak_o, 1);
        bus.tlp_ready_i = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        bus.dlc_state_i = 2'b00;
        send(3, 1'b0);
        chk("t6_down_valid", bus.tlp_valid_o, 0);
        chk("t6_down_data", bus.tlp_o, 0);
        chk("t6_down_req", bus.ack_req_o, 0);
        bus.dlc_state_i = 2'b11;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r, s;
            r = $urandom_range(0, 9);
            if (r < 5) s = m_next;
            else if (r < 7) s = m_next - 1 - $urandom_range(0, 5);
            else if (r < 9) s = m_next + 1 + $urandom_range(0, 5);
            else s = $urandom_range(0, MOD - 1);
            s = ((s % MOD) + MOD) % MOD;
            bus.seq_i       = SEQ_W'(s);
            bus.pkt_i       = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.pkt_valid_i = ($urandom_range(0, 9) < 7);
            bus.is_tlp_i    = ($urandom_range(0, 9) < 9);
            bus.lcrc_err_i  = ($urandom_range(0, 9) == 0);
            bus.tlp_ready_i = ($urandom_range(0, 9) < 6);
            bus.ack_ready_i = ($urandom_range(0, 9) < 6);
            bus.dlc_state_i = ($urandom_range(0, 99) < 3) ? 2'(($urandom_range(0, 2))) : 2'b11;
            rst             = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
